// File: rtl/main_mem_burst.sv
// ---------------------------------------------------------------------------
// main_mem_burst
//
// Clocked backing-store memory for the cache/TLB test systems. A request is
// accepted over a valid/ready handshake, then after LATENCY wait cycles a
// whole block of WORDS_PER_BLOCK words is moved, one word per cycle, strobed
// by beat_valid. A single-cycle done pulse closes every completed burst.
//
// Optional build feature (define the macro to enable):
//   MAIN_MEM_CRITICAL_WORD_FIRST_EN - the burst starts at the requested word
//     and wraps within the block; otherwise beats always run 0..WPB-1.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset (forces IDLE, abandons burst)
//   req_valid   request present
//   req_ready   block idle and able to accept a request (registered)
//   req_write   1 = write burst, 0 = read burst (sampled at acceptance)
//   req_addr    byte address of the requested word (sampled at acceptance)
//   wr_data     write word for the current beat (offset beat_idx)
//   beat_valid  beat active this cycle (registered)
//   beat_idx    word offset within the block for this beat (registered)
//   rd_data     read word for this beat, valid with beat_valid on reads
//   done        one-cycle pulse after the last beat of a burst
// ---------------------------------------------------------------------------
module main_mem_burst #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 32,
  parameter int DEPTH_WORDS     = 2 ** (ADDR_W - 2),
  parameter int WORDS_PER_BLOCK = 4,
  parameter int LATENCY         = 3,
  localparam int OFF_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              beat_valid,
  output logic [OFF_W-1:0]  beat_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              done
);

  // Word address = byte address without the two byte-offset bits; the block
  // number is the word address without the in-block offset bits.
  localparam int WORD_W = ADDR_W - 2;
  localparam int BLK_W  = WORD_W - OFF_W;
  // Wait counter holds LATENCY-1 down to 0.
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state;
  logic [BLK_W-1:0]  blk_q;      // block number of the accepted request
  logic              write_q;    // accepted request is a write
  logic [OFF_W-1:0]  start_q;    // offset of the first beat
  logic [CNT_W-1:0]  wait_cnt;   // remaining wait cycles minus one
  logic [OFF_W-1:0]  beat_cnt;   // remaining beats minus one

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [OFF_W-1:0]  req_off;
  logic [OFF_W-1:0]  rd_off;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] wr_word;

  // Offset of the first beat of a new burst.
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
  assign req_off = req_addr[OFF_W+1:2];
  logic unused_addr;
  assign unused_addr = ^req_addr[1:0];
`else
  assign req_off = '0;
  logic unused_addr;
  assign unused_addr = ^req_addr[OFF_W+1:0];
`endif

  // rd_data is registered and must line up with beat_valid, so the array is
  // read with the offset the *next* beat will carry: the first offset while
  // leaving WAIT, the incremented offset while inside BURST. The offset
  // counter is exactly OFF_W bits wide, so the increment wraps inside the
  // block by construction.
  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (here both arms of the ternary) so no latch is inferred.
  always_comb begin
    rd_off  = (state == ST_BURST) ? beat_idx + OFF_W'(1) : start_q;
    rd_word = {blk_q, rd_off};
    wr_word = {blk_q, beat_idx};
  end

  // Control FSM and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      beat_valid <= 1'b0;
      beat_idx   <= '0;
      rd_data    <= '0;
      done       <= 1'b0;
      blk_q      <= '0;
      write_q    <= 1'b0;
      start_q    <= '0;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            blk_q     <= req_addr[ADDR_W-1 -: BLK_W];
            write_q   <= req_write;
            start_q   <= req_off;
            wait_cnt  <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (wait_cnt == '0) begin
            beat_valid <= 1'b1;
            beat_idx   <= start_q;
            beat_cnt   <= OFF_W'(WORDS_PER_BLOCK - 1);
            if (!write_q) begin
              rd_data <= mem[rd_word];
            end
            state <= ST_BURST;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        ST_BURST: begin
          if (beat_cnt == '0) begin
            beat_valid <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else begin
            beat_idx <= beat_idx + OFF_W'(1);
            beat_cnt <= beat_cnt - OFF_W'(1);
            if (!write_q) begin
              rd_data <= mem[rd_word];
            end
          end
        end

        ST_DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage array. Write beats commit at the edge that ends the beat cycle.
  // Reset returns the FSM to IDLE at once, so an abandoned burst stops
  // writing immediately while already-written words are kept.
  // NOTE: the array has no reset; clearing it would need a per-word reset
  // network and would stop it mapping onto a RAM macro.
  always_ff @(posedge clock) begin
    if (state == ST_BURST && write_q) begin
      mem[wr_word] <= wr_data;
    end
  end

endmodule

// File: tb/tb_main_mem_burst.sv
// ---------------------------------------------------------------------------
// tb_main_mem_burst
//
// Self-checking bench for main_mem_burst. A request task issues bursts and
// pushes the expected beats (cycle, offset, data) and done cycle into queues,
// computed from a flat reference array and the timing rules. An independent
// monitor on the falling edge compares beat_valid / beat_idx / rd_data /
// done / req_ready every cycle against the queues. A second instance with
// LATENCY=1, WORDS_PER_BLOCK=8 covers the parameter sweep.
// ---------------------------------------------------------------------------
module tb_main_mem_burst;

  localparam int L = 3;
  localparam int W = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] wr_data = '0;
  logic        beat_valid;
  logic [1:0]  beat_idx;
  logic [31:0] rd_data;
  logic        done;

  // Sweep instance signals.
  logic        rv8 = 1'b0;
  logic        rdy8;
  logic [9:0]  ra8 = '0;
  logic        bv8;
  logic [2:0]  bi8;
  logic [31:0] rd8;
  logic        dn8;

  always #5 clock = ~clock;

  main_mem_burst dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .wr_data    (wr_data),
    .beat_valid (beat_valid),
    .beat_idx   (beat_idx),
    .rd_data    (rd_data),
    .done       (done)
  );

  main_mem_burst #(.LATENCY(1), .WORDS_PER_BLOCK(8)) dut8 (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (rv8),
    .req_ready  (rdy8),
    .req_write  (1'b0),
    .req_addr   (ra8),
    .wr_data    (32'h0),
    .beat_valid (bv8),
    .beat_idx   (bi8),
    .rd_data    (rd8),
    .done       (dn8)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  idx;
    logic [31:0] data;
    bit          rd;
  } beat_t;

  beat_t       beat_q[$];
  int          done_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] wbuf [W];
  int          cyc = 0;
  int          busy_until = 0;
  int          tests = 0;
  int          fails = 0;
  int          mon_cur;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    dut.mem[w] = v;
    ref_mem[w] = v;
  endtask

  task automatic check_reset_vals();
    check("rst_ready", req_ready, 1);
    check("rst_beat_valid", beat_valid, 0);
    check("rst_beat_idx", beat_idx, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
  endtask

  // Issue one burst. keep holds req_valid high after acceptance; abort_at
  // (>=0) pulls reset at the start of that beat of a write burst.
  task automatic do_req(input bit wr, input logic [9:0] addr, input bit keep,
                        input int abort_at, output int t);
    int n;
    int off0;
    int base;
    int offs [W];
    t = -1;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    t = cyc;
    if (!keep) req_valid = 1'b0;
    base = int'(addr[9:4]) * W;
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    off0 = int'(addr[3:2]);
`else
    off0 = 0;
`endif
    for (int k = 0; k < W; k++) begin
      beat_t b;
      offs[k] = (off0 + k) % W;
      b.cyc  = t + L + 1 + k;
      b.idx  = offs[k][1:0];
      b.data = ref_mem[base + offs[k]];
      b.rd   = !wr;
      beat_q.push_back(b);
    end
    done_q.push_back(t + L + W + 1);
    busy_until = t + L + W + 1;
    if (wr) begin
      repeat (L) begin
        @(posedge clock);
        #1;
      end
      for (int k = 0; k < W; k++) begin
        if (k == abort_at) begin
          reset_n = 1'b0;
          beat_q.delete();
          done_q.delete();
          busy_until = 0;
          @(negedge clock);
          check_reset_vals();
          @(negedge clock);
          reset_n = 1'b1;
          break;
        end
        wr_data = wbuf[offs[k]];
        ref_mem[base + offs[k]] = wbuf[offs[k]];
        @(posedge clock);
        #1;
      end
    end
  endtask

  // Scoreboard monitor: every falling edge, compare against the queues.
  always @(negedge clock) begin
    mon_cur = cyc + 1;
    if (beat_q.size() > 0 && beat_q[0].cyc == mon_cur) begin
      check("beat_valid", beat_valid, 1);
      check("beat_idx", beat_idx, beat_q[0].idx);
      if (beat_q[0].rd) check("rd_data", rd_data, beat_q[0].data);
      void'(beat_q.pop_front());
    end else begin
      check("beat_valid_idle", beat_valid, 0);
    end
    if (done_q.size() > 0 && done_q[0] == mon_cur) begin
      check("done", done, 1);
      void'(done_q.pop_front());
    end else begin
      check("done_idle", done, 0);
    end
    check("req_ready", req_ready, (mon_cur > busy_until) ? 1 : 0);
  end

  initial begin
    int t;
    int t1;
    int t2;
    int n;

    for (int i = 0; i < 256; i++) begin
      dut.mem[i]  = '0;
      dut8.mem[i] = '0;
      ref_mem[i]  = '0;
    end

    // Reset state.
    #12;
    check_reset_vals();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Read with default parameters.
    preload(16, 32'hCCCCCCCC);
    preload(17, 32'hEEEEEEEE);
    preload(18, 32'h55555555);
    preload(19, 32'hBBBBBBBB);
    do_req(1'b0, 10'h040, 1'b0, -1, t);

    // Write then read back.
    wbuf[0] = 32'h11111111;
    wbuf[1] = 32'h22222222;
    wbuf[2] = 32'h33333333;
    wbuf[3] = 32'h44444444;
    do_req(1'b1, 10'h100, 1'b0, -1, t);
    check("wr_word64", dut.mem[64], 32'h11111111);
    check("wr_word65", dut.mem[65], 32'h22222222);
    check("wr_word66", dut.mem[66], 32'h33333333);
    check("wr_word67", dut.mem[67], 32'h44444444);
    do_req(1'b0, 10'h10C, 1'b0, -1, t);

    // Critical-word ordering probe (order depends on build).
    do_req(1'b0, 10'h048, 1'b0, -1, t);

    // Busy handling: req_valid held high across two requests.
    for (int i = 0; i < 4; i++) begin
      preload(32 + i, $urandom);
      preload(48 + i, $urandom);
    end
    do_req(1'b0, 10'h084, 1'b1, -1, t1);
    do_req(1'b0, 10'h0C8, 1'b0, -1, t2);
    check("busy_spacing", t2 - t1, L + W + 2);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      for (int k = 0; k < W; k++) wbuf[k] = $urandom;
      do_req(wr, 10'($urandom_range(0, 1023)), 1'b0, -1, t);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    // Reset in the middle of a write burst.
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    preload(128, 32'h12800000);
    preload(129, 32'h12900000);
    preload(130, 32'h13013013);
    preload(131, 32'h13113113);
    wbuf[0] = 32'hA0A0A0A0;
    wbuf[1] = 32'hA1A1A1A1;
    wbuf[2] = 32'hA2A2A2A2;
    wbuf[3] = 32'hA3A3A3A3;
    do_req(1'b1, 10'h200, 1'b0, 2, t);
    @(negedge clock);
    for (int i = 0; i < 4; i++) check("abort_mem", dut.mem[128 + i], ref_mem[128 + i]);
    do_req(1'b0, 10'h200, 1'b0, -1, t);

    // Drain the scoreboard.
    n = 0;
    while ((beat_q.size() > 0 || done_q.size() > 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain", beat_q.size() + done_q.size(), 0);

    // Parameter sweep: LATENCY=1, WORDS_PER_BLOCK=8, read of 0x000.
    begin
      logic [31:0] ref8 [8];
      for (int i = 0; i < 8; i++) begin
        ref8[i] = $urandom;
        dut8.mem[i] = ref8[i];
      end
      @(negedge clock);
      rv8 = 1'b1;
      ra8 = 10'h000;
      n = 0;
      while (!rdy8 && n < 50) begin
        @(negedge clock);
        n++;
      end
      check("sweep_ready", rdy8, 1);
      @(posedge clock);
      #1;
      t = cyc;
      rv8 = 1'b0;
      for (int c = t + 1; c <= t + 11; c++) begin
        bit exp_bv;
        @(negedge clock);
        exp_bv = (c >= t + 2) && (c <= t + 9);
        check("sweep_beat_valid", bv8, exp_bv);
        if (exp_bv) begin
          check("sweep_beat_idx", bi8, c - t - 2);
          check("sweep_rd_data", rd8, ref8[c - t - 2]);
        end
        check("sweep_done", dn8, (c == t + 10) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/main_mem_burst.md
# main_mem_burst

Clocked, parametrised main memory for the cache/TLB test systems. It serves whole-block read and write bursts over a valid/ready request handshake, with a programmable access latency. Each word moves on a beat strobed by `beat_valid`, and a one-cycle `done` pulse ends the burst. It sits below the data cache or TLB miss handler as the backing store.

## Interface
- `ADDR_W`, 10, byte-address width.
- `DATA_W`, 32, word width.
- `DEPTH_WORDS`, 256, number of words, `2**(ADDR_W-2)`.
- `WORDS_PER_BLOCK`, 4, beats per burst; power of two, ≥2.
- `LATENCY`, 3, wait cycles between request acceptance and first beat; ≥1.
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block idle, can accept a request.
- `req_write` input 1: 1 = write burst, 0 = read burst (sampled at acceptance).
- `req_addr` input ADDR_W: byte address of requested word (sampled at acceptance).
- `wr_data` input DATA_W: write word for the current beat.
- `beat_valid` output 1: beat active this cycle.
- `beat_idx` output log2(WORDS_PER_BLOCK): word offset within block for this beat.
- `rd_data` output DATA_W: read word, valid while `beat_valid` and read burst.
- `done` output 1: one-cycle pulse, burst complete.

## Operation
- Word index = `req_addr[ADDR_W-1:2]`; byte-offset bits ignored. Block base = word index with low log2(WORDS_PER_BLOCK) bits cleared.
- FSM states:
  - IDLE: `req_ready`=1. `req_valid`&&`req_ready` latches addr/write and loads the latency counter → WAIT.
  - WAIT: counts LATENCY cycles → BURST.
  - BURST: WORDS_PER_BLOCK beats, one per cycle → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Read beat: `rd_data` = mem[base + `beat_idx`], registered, aligned with `beat_valid`.
- Write beat: mem[base + `beat_idx`] ← `wr_data` at the rising edge ending the beat cycle. Requester must drive the word for `beat_idx` during that cycle.
- Beat order: offset counter wraps modulo WORDS_PER_BLOCK and never leaves the block.
- Requests while busy: `req_ready`=0 outside IDLE; `req_valid` in those states is ignored, not queued.
- Array initialisation: zero at simulation start; not cleared by reset. Bench preloads by hierarchical write.
- Reset: `reset_n` low at any time forces IDLE immediately.
  - Reset values: `req_ready`=1 once released; `beat_valid`=0, `beat_idx`=0, `rd_data`=0, `done`=0.
  - Reset mid-burst abandons the burst. Words already written stay written; no `done` is issued.

## Timing
- Request accepted at edge T.
- WAIT occupies cycles T+1..T+LATENCY.
- Beats occupy cycles T+LATENCY+1..T+LATENCY+WORDS_PER_BLOCK.
- `done` is high in cycle T+LATENCY+WORDS_PER_BLOCK+1.
- `req_ready` rises the following cycle, so back-to-back requests have a minimum spacing of LATENCY+WORDS_PER_BLOCK+2 cycles.
- `beat_valid` is contiguous: no gaps or stalls inside a burst.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MAIN_MEM_CRITICAL_WORD_FIRST_EN` defined:
  - First beat is the requested word (`beat_idx` = `req_addr[log2(WPB)+1:2]`).
  - Subsequent beats increment and wrap within the block, e.g. for WPB=4, request offset 2 → 2,3,0,1.
- Undefined: beats always run 0,1,…,WORDS_PER_BLOCK-1 regardless of request offset.
- Timing is identical in both builds.

## Test plan
- Read, defaults:
  - Stimulus: preload words 16..19 = CCCCCCCC, EEEEEEEE, 55555555, BBBBBBBB; read request `req_addr`=0x040 at T.
  - Required: beats at T+4..T+7 return those values in order; `done` at T+8; `req_ready` high at T+9.
- Write then read:
  - Stimulus: write burst to 0x100 with data 11111111, 22222222, 33333333, 44444444.
  - Required: words 64..67 hold those values; a following read of 0x10C returns them.
- Critical word first (macro defined):
  - Stimulus: read 0x048.
  - Required: `beat_idx` 2,3,0,1; `rd_data` = word 18, 19, 16, 17.
  - Without the macro: `beat_idx` 0,1,2,3.
- Busy handling:
  - Stimulus: hold `req_valid`=1 continuously with two different addresses.
  - Required: the second request is accepted only after `done` + 1 cycle; its beats carry its own block's data.
- Reset mid-write:
  - Stimulus: assert `reset_n`=0 after beat 1 of a write to 0x200 (data A0, A1, A2, A3); release; read 0x200.
  - Required: words 128..129 = A0, A1; words 130..131 unchanged.
  - Required: during reset, `req_ready`=1 after release, and no `done` pulse.
- Parameter sweep:
  - Stimulus: `LATENCY`=1 and `WORDS_PER_BLOCK`=8, read of 0x000.
  - Required: 8 beats start at T+2; `done` at T+10.
